// File: rtl/lsu_wb_stage_pkg.sv
// Shared RV32I load/store encodings, FSM states and access helpers for the LSU stage.
package lsu_wb_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned CNT_W   = 8;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_e;

  // Op fields kept for the response phase; only the byte lane of the address is needed.
  typedef struct packed {
    logic [1:0]         lane;
    logic [2:0]         funct3;
    logic [RADDR_W-1:0] rd;
    logic               is_store;
  } lsu_op_t;

  function automatic logic op_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      FN3_B, FN3_H, FN3_W: ok = 1'b1;
      FN3_BU, FN3_HU:      ok = !is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] funct3,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    w = d;
    case (funct3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select with sign/zero extension; purely combinational.
module lsu_load_align
  import lsu_wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] shifted;

  // Word accesses are always aligned, so the shifted word equals rdata for them.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data_c  = shifted;
    case (funct3)
      FN3_B:   data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      FN3_H:   data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      FN3_BU:  data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
      FN3_HU:  data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// RV32I load/store + writeback stage: req/gnt/rvalid memory handshake,
// load alignment and register-file write strobe, with timeout abort.
module lsu_wb_stage
  import lsu_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         opcode_in,
  input  logic [2:0]         funct3_in,
  input  logic [XLEN-1:0]    base_in,
  input  logic [XLEN-1:0]    offset_in,
  input  logic [XLEN-1:0]    store_in,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [3:0]         mem_be,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               busy,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               err
);

  // Last counter value that may still be spent in REQ/WAIT before aborting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e         state_q, state_d;
  lsu_op_t            op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    addr_c, load_data_c;
  logic               is_store_c, is_mem_op_c, accept_ok_c;
  logic               mem_we_d;
  logic [XLEN-1:0]    mem_addr_d, mem_wdata_d, wb_data_d;
  logic [3:0]         mem_be_d;
  logic [RADDR_W-1:0] wb_rd_d;

  assign addr_c      = base_in + offset_in;
  assign is_store_c  = (opcode_in == OPC_STORE);
  assign is_mem_op_c = (opcode_in == OPC_LOAD) || is_store_c;
  assign accept_ok_c = op_legal(is_store_c, funct3_in) && !op_misaligned(funct3_in, addr_c[1:0]);

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (op_q.lane),
    .funct3 (op_q.funct3),
    .data_c (load_data_c)
  );

  // Next state, next captured op and next output values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    case (state_q)
      ST_IDLE: begin
        if (start && is_mem_op_c) begin
          op_d = '{lane: addr_c[1:0], funct3: funct3_in, rd: rd_in, is_store: is_store_c};
          if (accept_ok_c) begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_we_d    = is_store_c;
            mem_addr_d  = {addr_c[XLEN-1:2], 2'b00};
            mem_be_d    = byte_en(funct3_in, addr_c[1:0]);
            mem_wdata_d = store_lanes(funct3_in, store_in);
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_REQ: begin
        // A same-cycle rvalid is not looked at here: the grant alone moves us on.
        if (mem_gnt) begin
          state_d = op_q.is_store ? ST_IDLE : ST_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d   = ST_WB;
          wb_rd_d   = op_q.rd;
          wb_data_d = (op_q.rd == '0) ? '0 : load_data_c;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      mem_req   <= (state_d == ST_REQ);
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      busy      <= (state_d != ST_IDLE);
      wb_valid  <= (state_d == ST_WB);
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      err       <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Self-checking bench for lsu_wb_stage: directed corner cases plus random ops
// compared against an arithmetic model of the load/store rules.
module tb_lsu_wb_stage;

  localparam int unsigned TO        = 255;
  localparam logic [6:0]  OPC_LD    = 7'h03;
  localparam logic [6:0]  OPC_ST    = 7'h23;
  localparam logic [6:0]  OPC_OTHER = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] base_in, offset_in, store_in;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, wb_valid, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  lsu_wb_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in), .funct3_in(funct3_in),
    .base_in(base_in), .offset_in(offset_in), .store_in(store_in), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: effective address, enables, store lanes and load result.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic [31:0] sd, input logic [31:0] rdata,
                                output bit bad, output logic [31:0] ea_w,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld);
    logic [31:0] ea, v;
    int a, sz;
    bit st, legal;
    ea = base + off;
    a  = int'(ea % 32'd4);
    sz = int'(f3 % 3'd4);
    st = (opc == OPC_ST);
    legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bad  = !legal || (sz == 1 && (a % 2) != 0) || (sz == 2 && a != 0);
    ea_w = ea - 32'(a);
    if (sz == 0)      be = 4'(1 << a);
    else if (sz == 1) be = 4'(3 << a);
    else              be = 4'hF;
    if (sz == 0)      wd = {24'h0, sd[7:0]} * 32'h0101_0101;
    else if (sz == 1) wd = {16'h0, sd[15:0]} * 32'h0001_0001;
    else              wd = sd;
    v = rdata >> (8 * a);
    if (sz == 0) begin
      ld = v & 32'hFF;
      if (f3 < 3'd4 && ld >= 32'd128) ld = ld + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      ld = v & 32'hFFFF;
      if (f3 < 3'd4 && ld >= 32'd32768) ld = ld + 32'hFFFF_0000;
    end else begin
      ld = rdata;
    end
  endfunction

  task automatic drive_start(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] base,
                             input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
    opcode_in = opc; funct3_in = f3; base_in = base; offset_in = off; store_in = sd; rd_in = rd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One complete transaction with gd grant wait cycles and rdl rvalid wait cycles.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                        input logic [4:0] rd, input int gd, input int rdl, input logic [31:0] rdata);
    bit bad;
    logic [31:0] ea_w, wd, ld;
    logic [3:0] be;
    model(opc, f3, base, off, sd, rdata, bad, ea_w, be, wd, ld);
    drive_start(opc, f3, base, off, sd, rd);
    if (opc != OPC_LD && opc != OPC_ST) begin
      check({tag, "_ign_busy"}, 32'(busy), 32'd0);
      check({tag, "_ign_req"}, 32'(mem_req), 32'd0);
      check({tag, "_ign_err"}, 32'(err), 32'd0);
      return;
    end
    if (bad) begin
      check({tag, "_err"}, 32'(err), 32'd1);
      check({tag, "_err_req"}, 32'(mem_req), 32'd0);
      tick();
      check({tag, "_err_end"}, 32'(err), 32'd0);
      check({tag, "_err_req2"}, 32'(mem_req), 32'd0);
      check({tag, "_err_busy"}, 32'(busy), 32'd0);
      return;
    end
    check({tag, "_addr"}, mem_addr, ea_w);
    check({tag, "_be"}, 32'(mem_be), 32'(be));
    check({tag, "_we"}, 32'(mem_we), 32'(opc == OPC_ST));
    if (opc == OPC_ST) check({tag, "_wdata"}, mem_wdata, wd);
    for (int i = 0; i < gd; i++) begin
      check({tag, "_req_hold"}, 32'(mem_req), 32'd1);
      tick();
    end
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr_hold"}, mem_addr, ea_w);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    if (opc == OPC_ST) begin
      check({tag, "_st_busy"}, 32'(busy), 32'd0);
      check({tag, "_st_wb"}, 32'(wb_valid), 32'd0);
      return;
    end
    check({tag, "_ld_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < rdl; i++) begin
      check({tag, "_no_wb"}, 32'(wb_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, "_wb_data"}, wb_data, (rd == 5'd0) ? 32'd0 : ld);
    tick();
    check({tag, "_wb_once"}, 32'(wb_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [6:0] opc;
    logic [2:0] f3;
    rst = 1'b1; start = 1'b0; opcode_in = '0; funct3_in = '0; base_in = '0; offset_in = '0;
    store_in = '0; rd_in = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("sw", OPC_ST, 3'd2, 32'h100, 32'd4, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'h0);
    run_op("lb", OPC_LD, 3'd0, 32'h100, 32'd3, 32'h0, 5'd2, 0, 0, 32'h80FF_FFFF);
    run_op("lbu", OPC_LD, 3'd4, 32'h100, 32'd3, 32'h0, 5'd2, 0, 0, 32'h80FF_FFFF);
    run_op("lh", OPC_LD, 3'd1, 32'h100, 32'd2, 32'h0, 5'd3, 0, 0, 32'h8001_1234);
    run_op("lh_mis", OPC_LD, 3'd1, 32'h100, 32'd1, 32'h0, 5'd3, 0, 0, 32'h0);
    run_op("sh", OPC_ST, 3'd1, 32'h200, 32'd2, 32'h1234_ABCD, 5'd0, 1, 0, 32'h0);
    run_op("sbu_ill", OPC_ST, 3'd4, 32'h200, 32'd0, 32'h0, 5'd0, 0, 0, 32'h0);
    run_op("lw_wait", OPC_LD, 3'd2, 32'h400, 32'h10, 32'h0, 5'd17, 3, 2, 32'hCAFE_F00D);
    run_op("lw_rd0", OPC_LD, 3'd2, 32'h400, 32'h0, 32'h0, 5'd0, 0, 0, 32'h1234_5678);

    // Timeout: grant at once, then no rvalid ever arrives.
    drive_start(OPC_LD, 3'd2, 32'h500, 32'd0, 32'd0, 5'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n = 2;
    while (err !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("to_cycle", 32'(n), 32'(TO + 1));
    check("to_req", 32'(mem_req), 32'd0);
    check("to_wb", 32'(wb_valid), 32'd0);
    tick();
    check("to_busy", 32'(busy), 32'd0);
    check("to_err_end", 32'(err), 32'd0);

    // A second start while a load waits for grant must be ignored.
    drive_start(OPC_LD, 3'd2, 32'h300, 32'd0, 32'd0, 5'd7);
    drive_start(OPC_ST, 3'd2, 32'h600, 32'd0, 32'h5555_5555, 5'd8);
    check("busy_ign_addr", mem_addr, 32'h300);
    check("busy_ign_we", 32'(mem_we), 32'd0);
    check("busy_ign_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    check("busy_ign_wb", 32'(wb_valid), 32'd1);
    check("busy_ign_data", wb_data, 32'h0BAD_F00D);
    check("busy_ign_rd", 32'(wb_rd), 32'd7);
    tick();

    // Grant and rvalid together: the rvalid is not the load response.
    drive_start(OPC_LD, 3'd2, 32'h700, 32'd0, 32'd0, 5'd5);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("gr_same_nowb", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_rvalid = 1'b0;
    check("gr_same_wb", 32'(wb_valid), 32'd1);
    check("gr_same_data", wb_data, 32'h2222_2222);
    tick();

    // Reset while waiting for rvalid, then a stale rvalid.
    drive_start(OPC_LD, 3'd2, 32'h800, 32'd0, 32'd0, 5'd9);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_be", 32'(mem_be), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    mem_rvalid = 1'b0;
    check("stale_wb", 32'(wb_valid), 32'd0);
    check("stale_busy", 32'(busy), 32'd0);
    tick();
    check("stale_wb2", 32'(wb_valid), 32'd0);

    // Random operations against the model.
    for (int k = 0; k < 60; k++) begin
      n = int'($urandom_range(0, 9));
      opc = (n == 0) ? OPC_OTHER : (n < 5) ? OPC_LD : OPC_ST;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        n = int'($urandom_range(0, 4));
        f3 = (n == 3) ? 3'd4 : (n == 4) ? 3'd5 : 3'(n);
      end
      run_op("rnd", opc, f3, $urandom, 32'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
